i2c_txn_arbiter: RTL and testbench

Shares one i2c_master instance between NUM_REQ independent requesters (APB bridge, config loader, etc.).
- Arbitrates round-robin and latches the winner's address/rw/data.
- Sequences the master's enable/ready handshake and returns read data or a done/error pulse to the winner.
- Sits between the requesters and the i2c_master.

---
 rtl/i2c_bridge_pkg.sv | 17 +
 rtl/i2c_txn_arbiter_if.sv | 39 +++
 rtl/i2c_txn_arbiter_rr.sv | 32 +++
 rtl/i2c_txn_arbiter.sv | 141 ++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_bridge_pkg.sv
// Shared definitions for the I2C bridge: bus widths, transaction FSM
// encoding and the default per-transaction timeout.
package i2c_bridge_pkg;

  localparam int I2C_ADDR_W      = 7;
  localparam int I2C_DATA_W      = 8;
  localparam int TIMEOUT_DEFAULT = 4096;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } txn_state_t;

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Bundle between the requesters, the transaction arbiter and the shared
// i2c_master. The arbiter uses the slave view; the environment (requesters
// plus master) uses the master view.
interface i2c_txn_arbiter_if
  import i2c_bridge_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  // Requester side
  logic [NUM_REQ-1:0]            req;
  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_rw;
  logic [I2C_DATA_W*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic                          err;
  logic [I2C_DATA_W-1:0]         rdata;
  logic                          busy;

  // i2c_master side
  logic                          m_enable;
  logic [I2C_ADDR_W-1:0]         m_addr;
  logic                          m_rw;
  logic [I2C_DATA_W-1:0]         m_data_in;
  logic                          m_ready;
  logic [I2C_DATA_W-1:0]         m_data_out;

  modport slave (
    input  req, req_addr, req_rw, req_wdata, m_ready, m_data_out,
    output gnt, done, err, rdata, busy, m_enable, m_addr, m_rw, m_data_in
  );

  modport master (
    output req, req_addr, req_rw, req_wdata, m_ready, m_data_out,
    input  gnt, done, err, rdata, busy, m_enable, m_addr, m_rw, m_data_in
  );

endinterface

// File: rtl/i2c_txn_arbiter_rr.sv
// Combinational rotating-priority arbiter: picks the first set request
// starting at ptr and searching upward with wrap-around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic found;
  int   cand;

  // Walk the requests in priority order; the first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one i2c_master between NUM_REQ requesters. A round-robin winner's
// address/rw/data are latched, the master's enable/ready handshake is
// sequenced, and a done (plus err on timeout) pulse goes back to the winner.
module i2c_txn_arbiter
  import i2c_bridge_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  i2c_txn_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  txn_state_t              state;
  logic [IDX_W-1:0]        ptr;
  logic [CNT_W-1:0]        cnt;
  logic                    timed_out;

  logic [NUM_REQ-1:0]      win_gnt;
  logic [IDX_W-1:0]        win_idx;

  logic [I2C_ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [I2C_DATA_W-1:0]   wdata_arr [NUM_REQ];

  logic [NUM_REQ-1:0]      gnt_reg;
  logic [NUM_REQ-1:0]      done_reg;
  logic                    err_reg;
  logic [I2C_DATA_W-1:0]   rdata_reg;
  logic                    busy_reg;
  logic                    m_enable_reg;
  logic [I2C_ADDR_W-1:0]   m_addr_reg;
  logic                    m_rw_reg;
  logic [I2C_DATA_W-1:0]   m_data_in_reg;

  // Split the packed per-requester fields so the winner can be picked by index.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus.req_addr[gi*I2C_ADDR_W +: I2C_ADDR_W];
    assign wdata_arr[gi] = bus.req_wdata[gi*I2C_DATA_W +: I2C_DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (win_gnt),
    .idx   (win_idx)
  );

  // The last counted wait cycle; reaching it aborts the transaction.
  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      gnt_reg       <= '0;
      done_reg      <= '0;
      err_reg       <= 1'b0;
      rdata_reg     <= '0;
      busy_reg      <= 1'b0;
      m_enable_reg  <= 1'b0;
      m_addr_reg    <= '0;
      m_rw_reg      <= 1'b0;
      m_data_in_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          // m_ready gating keeps a master that is still stuck from a timed-out
          // transaction from being enabled a second time.
          if (|bus.req && bus.m_ready) begin
            gnt_reg       <= win_gnt;
            busy_reg      <= 1'b1;
            m_addr_reg    <= addr_arr[win_idx];
            m_rw_reg      <= bus.req_rw[win_idx];
            m_data_in_reg <= wdata_arr[win_idx];
            ptr           <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          m_enable_reg <= 1'b1;
          cnt          <= '0;
          state        <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // The master usually still shows ready on the first cycle here.
          m_enable_reg <= 1'b0;
          if (timed_out) begin
            done_reg <= gnt_reg;
            err_reg  <= 1'b1;
            state    <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
            if (!bus.m_ready) state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (bus.m_ready) begin
            if (m_rw_reg) rdata_reg <= bus.m_data_out;
            done_reg <= gnt_reg;
            err_reg  <= 1'b0;
            state    <= RESP;
          end else if (timed_out) begin
            done_reg <= gnt_reg;
            err_reg  <= 1'b1;
            state    <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          done_reg <= '0;
          err_reg  <= 1'b0;
          gnt_reg  <= '0;
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.done      = done_reg;
  assign bus.err       = err_reg;
  assign bus.rdata     = rdata_reg;
  assign bus.busy      = busy_reg;
  assign bus.m_enable  = m_enable_reg;
  assign bus.m_addr    = m_addr_reg;
  assign bus.m_rw      = m_rw_reg;
  assign bus.m_data_in = m_data_in_reg;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter with a small behavioural i2c_master.
module tb_i2c_txn_arbiter;
  import i2c_bridge_pkg::*;

  localparam int N  = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_txn_arbiter_if #(.NUM_REQ(N)) bus ();

  i2c_txn_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Master model: drops ready the cycle after enable, raises it mdl_lat
  // cycles later with mdl_dout, or never while mdl_stuck is set.
  int          mdl_lat   = 40;
  bit          mdl_stuck = 1'b0;
  logic [7:0]  mdl_dout  = 8'h00;
  int          mdl_cnt   = 0;

  always @(posedge clk) begin
    if (rst) begin
      bus.m_ready    <= 1'b1;
      bus.m_data_out <= 8'h00;
      mdl_cnt        <= 0;
    end else if (bus.m_enable) begin
      bus.m_ready <= 1'b0;
      mdl_cnt     <= mdl_lat;
    end else if (!bus.m_ready && !mdl_stuck) begin
      if (mdl_cnt <= 1) begin
        bus.m_ready    <= 1'b1;
        bus.m_data_out <= mdl_dout;
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  // One-hot watch and grant-event counter.
  int          bad_hot   = 0;
  int          grant_evt = 0;
  logic [N-1:0] gnt_prev = '0;

  always @(negedge clk) begin
    if (((bus.gnt & (bus.gnt - 1'b1)) != 0) || ((bus.done & (bus.done - 1'b1)) != 0))
      bad_hot++;
    if (bus.gnt != 0 && gnt_prev == 0) grant_evt++;
    gnt_prev = bus.gnt;
  end

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic wait_gnt(input string tag, input int bound);
    int k;
    k = 0;
    while (k < bound && bus.gnt == 0) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " gnt_seen"}, (bus.gnt != 0), 1);
  endtask

  task automatic wait_done(input string tag, input int bound, output int cyc);
    cyc = 0;
    while (cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (bus.done != 0) break;
    end
    chk({tag, " done_seen"}, (bus.done != 0), 1);
  endtask

  // Full transaction for requester idx with 40-cycle master latency.
  task automatic txn(input string nm, input int idx, input logic [6:0] addr, input logic rw,
                     input logic [7:0] wd, input logic [7:0] md, input logic [7:0] exp_rdata);
    int k, extra_en, hold_bad;
    mdl_lat  = 40;
    mdl_dout = md;
    bus.req_addr[idx*7 +: 7]  = addr;
    bus.req_wdata[idx*8 +: 8] = wd;
    bus.req_rw[idx]           = rw;
    bus.req[idx]              = 1'b1;
    @(negedge clk);
    chk({nm, " gnt"}, bus.gnt, 32'(1) << idx);
    chk({nm, " busy"}, bus.busy, 1);
    chk({nm, " en_early"}, bus.m_enable, 0);
    @(negedge clk);
    chk({nm, " en"}, bus.m_enable, 1);
    chk({nm, " m_addr"}, bus.m_addr, addr);
    chk({nm, " m_rw"}, bus.m_rw, rw);
    chk({nm, " m_data_in"}, bus.m_data_in, wd);
    k = 0; extra_en = 0; hold_bad = 0;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (bus.m_enable) extra_en++;
      if (bus.gnt != (N'(1) << idx) || bus.m_addr != addr || bus.m_data_in != wd || bus.m_rw != rw)
        hold_bad++;
      if (bus.done != 0) break;
    end
    chk({nm, " latency"}, k, 42);
    chk({nm, " done"}, bus.done, 32'(1) << idx);
    chk({nm, " err"}, bus.err, 0);
    chk({nm, " rdata"}, bus.rdata, exp_rdata);
    chk({nm, " extra_en"}, extra_en, 0);
    chk({nm, " hold"}, hold_bad, 0);
    bus.req[idx] = 1'b0;
    @(negedge clk);
    chk({nm, " done_pulse"}, bus.done, 0);
    chk({nm, " busy_clr"}, bus.busy, 0);
    chk({nm, " gnt_clr"}, bus.gnt, 0);
    $display("txn %s idx=%0d addr=%02h rw=%0d rdata=%02h", nm, idx, addr, rw, bus.rdata);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int cyc, n, evt;
    int order [6];
    logic [N-1:0] prev;

    rst           = 1'b1;
    bus.req       = '0;
    bus.req_addr  = '0;
    bus.req_rw    = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst gnt", bus.gnt, 0);
    chk("rst done", bus.done, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst m_enable", bus.m_enable, 0);
    chk("rst err", bus.err, 0);
    chk("rst rdata", bus.rdata, 0);
    chk("rst m_addr", bus.m_addr, 0);
    chk("rst m_data_in", bus.m_data_in, 0);
    rst = 1'b0;
    @(negedge clk);

    // Write then read; rdata must ignore master data on the write.
    txn("write", 0, 7'h50, 1'b0, 8'hA5, 8'h33, 8'h00);
    txn("read",  2, 7'h3C, 1'b1, 8'h00, 8'h7E, 8'h7E);

    // Requester 1 drops req while the master is busy.
    mdl_lat = 40;
    bus.req_addr[7 +: 7]  = 7'h21;
    bus.req_wdata[8 +: 8] = 8'h5A;
    bus.req_rw[1]         = 1'b0;
    bus.req[1]            = 1'b1;
    @(negedge clk);
    chk("drop gnt", bus.gnt, 4'b0010);
    @(negedge clk);
    chk("drop en", bus.m_enable, 1);
    @(negedge clk);
    bus.req[1] = 1'b0;
    wait_done("drop", 100, cyc);
    chk("drop done", bus.done, 4'b0010);
    chk("drop err", bus.err, 0);
    evt = grant_evt;
    repeat (10) @(negedge clk);
    chk("drop regrant", grant_evt - evt, 0);
    chk("drop gnt_idle", bus.gnt, 0);
    $display("txn drop idx=1 completed after req withdrawn");

    // Fairness: 0,1,3 held from reset.
    rst     = 1'b1;
    bus.req = 4'b1011;
    mdl_lat = 3;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    n    = 0;
    prev = '0;
    for (int c = 0; c < 400 && n < 6; c++) begin
      @(negedge clk);
      if (bus.gnt != 0 && prev == 0) begin
        order[n] = oh_idx(bus.gnt);
        n++;
      end
      prev = bus.gnt;
    end
    bus.req = '0;
    chk("fair count", n, 6);
    chk("fair g0", order[0], 0);
    chk("fair g1", order[1], 1);
    chk("fair g2", order[2], 3);
    chk("fair g3", order[3], 0);
    chk("fair g4", order[4], 1);
    chk("fair g5", order[5], 3);
    for (int c = 0; c < 100 && bus.busy; c++) @(negedge clk);
    @(negedge clk);
    chk("fair drained", bus.busy, 0);
    $display("txn fairness order %0d %0d %0d %0d %0d %0d",
             order[0], order[1], order[2], order[3], order[4], order[5]);

    // Timeout: master never returns ready.
    mdl_stuck = 1'b1;
    mdl_lat   = 3;
    mdl_dout  = 8'h99;
    bus.req_addr[0 +: 7] = 7'h11;
    bus.req_rw[0]        = 1'b1;
    bus.req[0]           = 1'b1;
    @(negedge clk);
    chk("to gnt", bus.gnt, 4'b0001);
    @(negedge clk);
    chk("to en", bus.m_enable, 1);
    bus.req[0] = 1'b0;
    wait_done("to", 200, cyc);
    chk("to cycles", cyc, 64);
    chk("to done", bus.done, 4'b0001);
    chk("to err", bus.err, 1);
    chk("to rdata", bus.rdata, 8'h00);
    @(negedge clk);
    chk("to done_pulse", bus.done, 0);
    chk("to err_clr", bus.err, 0);
    bus.req_rw[1] = 1'b0;
    bus.req[1]    = 1'b1;
    evt = grant_evt;
    repeat (20) @(negedge clk);
    chk("to blocked", grant_evt - evt, 0);
    mdl_stuck = 1'b0;
    wait_gnt("to release", 20);
    chk("to regrant", bus.gnt, 4'b0010);
    wait_done("to serve", 100, cyc);
    chk("to serve done", bus.done, 4'b0010);
    chk("to serve err", bus.err, 0);
    bus.req[1] = 1'b0;
    @(negedge clk);
    $display("txn timeout idx=0 aborted, pending idx=1 served");

    // Reset in WAIT_DONE.
    mdl_lat = 40;
    bus.req = 4'b1111;
    @(negedge clk);
    chk("rm gnt", bus.gnt, 4'b0100);
    @(negedge clk);
    chk("rm en", bus.m_enable, 1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rm gnt0", bus.gnt, 0);
    chk("rm busy0", bus.busy, 0);
    chk("rm en0", bus.m_enable, 0);
    chk("rm done0", bus.done, 0);
    chk("rm addr0", bus.m_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rm first", bus.gnt, 4'b0001);
    bus.req = '0;
    wait_done("rm", 100, cyc);
    chk("rm done", bus.done, 4'b0001);
    $display("txn reset-mid recovered with idx=0 first");

    chk("onehot", bad_hot, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
